// File: rtl/coprocessor0_regfile.sv
// CP0 architectural register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Takes MTC0 writes and exception/eret events committed at writeback, serves MFC0
// reads combinationally, and produces the EPC redirect and interrupt-pending signal.
`timescale 1ns/1ps
module coprocessor0_regfile #(
  parameter int COUNT_TICK_DIVIDE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_write_enabled,
  input  logic [4:0]  wb_address_register,
  input  logic [2:0]  wb_address_select,
  input  logic [31:0] wb_write_data,
  input  logic [4:0]  read_address_register,
  input  logic [2:0]  read_address_select,
  output logic [31:0] read_data,
  input  logic        exception_valid,
  input  logic [4:0]  exception_code,
  input  logic [31:0] exception_pc,
  input  logic        exception_delay_slot,
  input  logic        exception_bad_vaddr_valid,
  input  logic [31:0] exception_bad_vaddr,
  input  logic        eret_valid,
  input  logic [5:0]  hardware_interrupt,
  output logic [31:0] epc,
  output logic        status_exception_level,
  output logic        interrupt_pending
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  // BEV (bit 22) is hard-wired to 1.
  localparam logic [31:0] STATUS_BEV = 32'h0040_0000;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  status_im_q, status_im_d;
  logic        status_exl_q, status_exl_d;
  logic        status_ie_q, status_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic        cause_ti_q, cause_ti_d;
  logic [5:0]  cause_ip_hw_q, cause_ip_hw_d;
  logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
  logic [4:0]  cause_exc_code_q, cause_exc_code_d;
  logic        tick_div_q, tick_div_d;

  logic [31:0] status_value;
  logic [31:0] cause_value;
  logic        count_tick;
  logic        mtc0_go;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;

  assign status_value = STATUS_BEV
                      | {16'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
  assign cause_value  = {cause_bd_q, cause_ti_q, 14'd0, cause_ip_hw_q, cause_ip_sw_q,
                         1'b0, cause_exc_code_q, 2'b00};

  // With a divide of 1 Count advances every cycle, otherwise on alternate cycles.
  assign count_tick = (COUNT_TICK_DIVIDE == 1) ? 1'b1 : tick_div_q;

  // An MTC0 that coincides with an exception or eret is discarded entirely,
  // including its effect on Count and Compare.
  assign mtc0_go    = wb_write_enabled & ~exception_valid & ~eret_valid
                    & (wb_address_select == 3'd0);
  assign wr_count   = mtc0_go & (wb_address_register == REG_COUNT);
  assign wr_compare = mtc0_go & (wb_address_register == REG_COMPARE);
  assign wr_status  = mtc0_go & (wb_address_register == REG_STATUS);
  assign wr_cause   = mtc0_go & (wb_address_register == REG_CAUSE);
  assign wr_epc     = mtc0_go & (wb_address_register == REG_EPC);

  assign interrupt_pending = status_ie_q & ~status_exl_q
                           & (|({cause_ip_hw_q, cause_ip_sw_q} & status_im_q));
  assign epc                    = epc_q;
  assign status_exception_level = status_exl_q;

  // Next-state: timer, interrupt sampling, then exception > eret > MTC0.
  always_comb begin
    badvaddr_d       = badvaddr_q;
    count_d          = count_q;
    compare_d        = compare_q;
    epc_d            = epc_q;
    status_im_d      = status_im_q;
    status_exl_d     = status_exl_q;
    status_ie_d      = status_ie_q;
    cause_bd_d       = cause_bd_q;
    cause_ti_d       = cause_ti_q;
    cause_ip_sw_d    = cause_ip_sw_q;
    cause_exc_code_d = cause_exc_code_q;
    tick_div_d       = ~tick_div_q;

    if (count_tick) begin
      count_d = count_q + 32'd1;
    end
    if (wr_count) begin
      count_d    = wb_write_data;
      tick_div_d = 1'b0;
    end

    if (count_q == compare_q) begin
      cause_ti_d = 1'b1;
    end
    if (wr_compare) begin
      compare_d  = wb_write_data;
      cause_ti_d = 1'b0;
    end

    cause_ip_hw_d = {hardware_interrupt[5] | cause_ti_q, hardware_interrupt[4:0]};

    if (exception_valid) begin
      if (!status_exl_q) begin
        epc_d      = exception_delay_slot ? (exception_pc - 32'd4) : exception_pc;
        cause_bd_d = exception_delay_slot;
      end
      status_exl_d     = 1'b1;
      cause_exc_code_d = exception_code;
      if (exception_bad_vaddr_valid) begin
        badvaddr_d = exception_bad_vaddr;
      end
    end else if (eret_valid) begin
      status_exl_d = 1'b0;
    end else begin
      if (wr_status) begin
        status_im_d  = wb_write_data[15:8];
        status_exl_d = wb_write_data[1];
        status_ie_d  = wb_write_data[0];
      end
      if (wr_cause) begin
        cause_ip_sw_d = wb_write_data[9:8];
      end
      if (wr_epc) begin
        epc_d = wb_write_data;
      end
    end
  end

  // Register state with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      badvaddr_q       <= 32'd0;
      count_q          <= 32'd0;
      compare_q        <= 32'd0;
      epc_q            <= 32'd0;
      status_im_q      <= 8'd0;
      status_exl_q     <= 1'b0;
      status_ie_q      <= 1'b0;
      cause_bd_q       <= 1'b0;
      cause_ti_q       <= 1'b0;
      cause_ip_hw_q    <= 6'd0;
      cause_ip_sw_q    <= 2'd0;
      cause_exc_code_q <= 5'd0;
      tick_div_q       <= 1'b0;
    end else begin
      badvaddr_q       <= badvaddr_d;
      count_q          <= count_d;
      compare_q        <= compare_d;
      epc_q            <= epc_d;
      status_im_q      <= status_im_d;
      status_exl_q     <= status_exl_d;
      status_ie_q      <= status_ie_d;
      cause_bd_q       <= cause_bd_d;
      cause_ti_q       <= cause_ti_d;
      cause_ip_hw_q    <= cause_ip_hw_d;
      cause_ip_sw_q    <= cause_ip_sw_d;
      cause_exc_code_q <= cause_exc_code_d;
      tick_div_q       <= tick_div_d;
    end
  end

  // MFC0 read port: select 0 only, unmapped registers read zero.
  always_comb begin
    read_data = 32'd0;
    if (read_address_select == 3'd0) begin
      case (read_address_register)
        REG_BADVADDR: read_data = badvaddr_q;
        REG_COUNT:    read_data = count_q;
        REG_COMPARE:  read_data = compare_q;
        REG_STATUS:   read_data = status_value;
        REG_CAUSE:    read_data = cause_value;
        REG_EPC:      read_data = epc_q;
        default:      read_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_coprocessor0_regfile.sv
// Directed bench for coprocessor0_regfile: hand-computed vectors, one line per check.
`timescale 1ns/1ps
module tb_coprocessor0_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_write_enabled;
  logic [4:0]  wb_address_register;
  logic [2:0]  wb_address_select;
  logic [31:0] wb_write_data;
  logic [4:0]  read_address_register;
  logic [2:0]  read_address_select;
  logic [31:0] read_data;
  logic        exception_valid;
  logic [4:0]  exception_code;
  logic [31:0] exception_pc;
  logic        exception_delay_slot;
  logic        exception_bad_vaddr_valid;
  logic [31:0] exception_bad_vaddr;
  logic        eret_valid;
  logic [5:0]  hardware_interrupt;
  logic [31:0] epc;
  logic        status_exception_level;
  logic        interrupt_pending;

  int vectors = 0;
  int miscompares = 0;

  coprocessor0_regfile #(.COUNT_TICK_DIVIDE(2)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .wb_write_enabled          (wb_write_enabled),
    .wb_address_register       (wb_address_register),
    .wb_address_select         (wb_address_select),
    .wb_write_data             (wb_write_data),
    .read_address_register     (read_address_register),
    .read_address_select       (read_address_select),
    .read_data                 (read_data),
    .exception_valid           (exception_valid),
    .exception_code            (exception_code),
    .exception_pc              (exception_pc),
    .exception_delay_slot      (exception_delay_slot),
    .exception_bad_vaddr_valid (exception_bad_vaddr_valid),
    .exception_bad_vaddr       (exception_bad_vaddr),
    .eret_valid                (eret_valid),
    .hardware_interrupt        (hardware_interrupt),
    .epc                       (epc),
    .status_exception_level    (status_exception_level),
    .interrupt_pending         (interrupt_pending)
  );

  always #50 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) begin
      $display("check %-22s observed=0x%08h expected=0x%08h ok", tag, obs, exp);
    end else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [2:0] s,
                         input logic [31:0] exp);
    read_address_register = r;
    read_address_select   = s;
    #1;
    chk(tag, read_data, exp);
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
    wb_write_enabled    = 1'b1;
    wb_address_register = r;
    wb_address_select   = s;
    wb_write_data       = d;
    step();
    wb_write_enabled    = 1'b0;
  endtask

  task automatic set_exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                         input logic bv, input logic [31:0] bad);
    exception_valid           = 1'b1;
    exception_code            = code;
    exception_pc              = pc;
    exception_delay_slot      = ds;
    exception_bad_vaddr_valid = bv;
    exception_bad_vaddr       = bad;
  endtask

  initial begin
    reset = 1'b1;
    wb_write_enabled = 1'b0; wb_address_register = 5'd0; wb_address_select = 3'd0;
    wb_write_data = 32'd0; read_address_register = 5'd0; read_address_select = 3'd0;
    exception_valid = 1'b0; exception_code = 5'd0; exception_pc = 32'd0;
    exception_delay_slot = 1'b0; exception_bad_vaddr_valid = 1'b0;
    exception_bad_vaddr = 32'd0; eret_valid = 1'b0; hardware_interrupt = 6'd0;

    // Power-on reset state
    step(); step();
    reset = 1'b0;
    chk_reg("por_status", 5'd12, 3'd0, 32'h0040_0000);
    chk_reg("por_cause",  5'd13, 3'd0, 32'h0000_0000);
    chk_reg("por_count",  5'd9,  3'd0, 32'h0000_0000);
    chk("por_epc", epc, 32'h0);
    chk("por_pending", {31'd0, interrupt_pending}, 32'h0);

    // Mid-run asynchronous reset (TI has set since Count==Compare==0)
    mtc0(5'd9, 3'd0, 32'h0000_1234);
    mtc0(5'd12, 3'd0, 32'h0000_8001);
    chk_reg("pre_rst_count", 5'd9, 3'd0, 32'h0000_1234);
    chk("pre_rst_pending", {31'd0, interrupt_pending}, 32'h1);
    reset = 1'b1;
    #2;
    chk_reg("arst_status", 5'd12, 3'd0, 32'h0040_0000);
    chk_reg("arst_count",  5'd9,  3'd0, 32'h0000_0000);
    chk("arst_epc", epc, 32'h0);
    chk("arst_pending", {31'd0, interrupt_pending}, 32'h0);
    step();
    reset = 1'b0;

    // Writable-field masks; Compare write keeps TI clear
    mtc0(5'd11, 3'd0, 32'hFFFF_0000);
    mtc0(5'd12, 3'd0, 32'hFFFF_FFFF);
    chk_reg("status_mask", 5'd12, 3'd0, 32'h0040_FF03);
    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    chk_reg("cause_mask", 5'd13, 3'd0, 32'h0000_0300);
    chk("exl_masks_pending", {31'd0, interrupt_pending}, 32'h0);
    mtc0(5'd12, 3'd1, 32'h0000_0000);
    chk_reg("sel1_write_ignored", 5'd12, 3'd0, 32'h0040_FF03);
    chk_reg("sel1_reads_zero", 5'd12, 3'd1, 32'h0);
    chk_reg("unmapped_reads_zero", 5'd15, 3'd0, 32'h0);
    mtc0(5'd12, 3'd0, 32'h0);
    mtc0(5'd13, 3'd0, 32'h0);

    // Count wrap at divide 2
    mtc0(5'd9, 3'd0, 32'hFFFF_FFFE);
    chk_reg("count_load", 5'd9, 3'd0, 32'hFFFF_FFFE);
    step();
    chk_reg("count_hold_half", 5'd9, 3'd0, 32'hFFFF_FFFE);
    step();
    chk_reg("count_ffffffff", 5'd9, 3'd0, 32'hFFFF_FFFF);
    step(); step();
    chk_reg("count_wrap", 5'd9, 3'd0, 32'h0);

    // Timer interrupt
    mtc0(5'd11, 3'd0, 32'd5);
    repeat (9) step();
    chk_reg("count_at_5", 5'd9, 3'd0, 32'd5);
    chk_reg("ti_not_yet", 5'd13, 3'd0, 32'h0);
    step();
    chk_reg("ti_set", 5'd13, 3'd0, 32'h4000_0000);
    mtc0(5'd12, 3'd0, 32'h0000_8001);
    chk_reg("ti_ip15", 5'd13, 3'd0, 32'h4000_8000);
    chk("timer_pending", {31'd0, interrupt_pending}, 32'h1);
    mtc0(5'd11, 3'd0, 32'd100);
    chk_reg("ti_cleared", 5'd13, 3'd0, 32'h0000_8000);
    step();
    chk_reg("ip15_dropped", 5'd13, 3'd0, 32'h0);
    chk("timer_pending_off", {31'd0, interrupt_pending}, 32'h0);
    mtc0(5'd12, 3'd0, 32'h0);

    // Exception in a delay slot with BadVAddr
    set_exc(5'd4, 32'hBFC0_0100, 1'b1, 1'b1, 32'h0000_0003);
    step();
    exception_valid = 1'b0;
    chk("exc_epc", epc, 32'hBFC0_00FC);
    chk_reg("exc_cause", 5'd13, 3'd0, 32'h8000_0010);
    chk_reg("exc_badvaddr", 5'd8, 3'd0, 32'h3);
    chk_reg("exc_status", 5'd12, 3'd0, 32'h0040_0002);
    chk("exc_exl", {31'd0, status_exception_level}, 32'h1);

    // Nested exception with EXL=1
    set_exc(5'd12, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_DEAD);
    step();
    exception_valid = 1'b0;
    chk("nested_epc", epc, 32'hBFC0_00FC);
    chk_reg("nested_cause", 5'd13, 3'd0, 32'h8000_0030);
    chk_reg("nested_badvaddr", 5'd8, 3'd0, 32'h3);

    // eret, then exception+eret+MTC0 in one cycle
    eret_valid = 1'b1;
    step();
    eret_valid = 1'b0;
    chk("eret_exl", {31'd0, status_exception_level}, 32'h0);
    chk("eret_epc", epc, 32'hBFC0_00FC);
    set_exc(5'd5, 32'h0040_0020, 1'b0, 1'b1, 32'h0000_0101);
    eret_valid = 1'b1;
    mtc0(5'd14, 3'd0, 32'h0000_1000);
    exception_valid = 1'b0;
    eret_valid = 1'b0;
    chk("prio_epc", epc, 32'h0040_0020);
    chk("prio_exl", {31'd0, status_exception_level}, 32'h1);
    chk_reg("prio_cause", 5'd13, 3'd0, 32'h0000_0014);
    chk_reg("prio_badvaddr", 5'd8, 3'd0, 32'h0000_0101);
    eret_valid = 1'b1;
    mtc0(5'd14, 3'd0, 32'h0000_2000);
    eret_valid = 1'b0;
    chk("eret_over_mtc0_exl", {31'd0, status_exception_level}, 32'h0);
    chk("eret_over_mtc0_epc", epc, 32'h0040_0020);

    // pc-4 wraps modulo 2^32
    set_exc(5'd6, 32'h0000_0002, 1'b1, 1'b0, 32'h0);
    step();
    exception_valid = 1'b0;
    chk("wrap_epc", epc, 32'hFFFF_FFFE);
    chk_reg("wrap_cause", 5'd13, 3'd0, 32'h8000_0018);
    eret_valid = 1'b1;
    step();
    eret_valid = 1'b0;
    mtc0(5'd8, 3'd0, 32'h0000_FFFF);
    chk_reg("badvaddr_readonly", 5'd8, 3'd0, 32'h0000_0101);

    // Hardware interrupt line 0 through IM2
    hardware_interrupt = 6'b000001;
    mtc0(5'd12, 3'd0, 32'h0000_0401);
    step();
    chk("hw_pending", {31'd0, interrupt_pending}, 32'h1);
    chk_reg("hw_cause", 5'd13, 3'd0, 32'h8000_0418);
    mtc0(5'd12, 3'd0, 32'h0000_0403);
    chk("hw_exl_masks", {31'd0, interrupt_pending}, 32'h0);
    hardware_interrupt = 6'b000000;
    mtc0(5'd12, 3'd0, 32'h0000_0401);
    chk("hw_released", {31'd0, interrupt_pending}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
